rle_encode_fifo: RTL and testbench

// - Run-length encoder with output FIFO; counterpart of the RLE decode FIFO.
// - Absorbs a byte stream and closes runs of equal bytes into (char, count) pairs.
// - Buffers pairs in a DEPTH-entry FIFO and presents them on data_o/cnt_o.
// - The pair format matches the decode side's data_din/data_cin inputs, so the output connects directly to it.

---
 rtl/rle_pkg.sv | 15 +
 rtl/rle_pair_fifo.sv | 72 +++++++
 rtl/rle_encode_fifo.sv | 117 +++++++++++
 tb/tb_rle_encode_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared types and widths for the run-length encoder and its pair FIFO.
package rle_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] RMAX = '1;

   typedef enum logic {IDLE, RUN} rle_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] chr;
      logic [CNT_W-1:0]  cnt;
   } rle_pair_t;

endpackage

// File: rtl/rle_pair_fifo.sv
// Synchronous FIFO of (char, count) pairs with registered read data and a
// one-cycle valid pulse per pop.
module rle_pair_fifo
   import rle_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  rle_pair_t wdata_i,
   input  logic      pop_i,
   output rle_pair_t rdata_o,
   output logic      rvalid_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   rle_pair_t   mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   rle_pair_t   rdata_q;
   logic        rvalid_q;
   logic        full_q, full_d;
   logic        empty_q, empty_d;
   logic        do_push, do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   // Flags are computed from the next pointers so they track the pointer registers exactly.
   always_comb begin
      wptr_d  = wptr_q + (AW+1)'(do_push);
      rptr_d  = rptr_q + (AW+1)'(do_pop);
      full_d  = (wptr_d ^ rptr_d) == {1'b1, {AW{1'b0}}};
      empty_d = (wptr_d == rptr_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         rvalid_q <= do_pop;
         if (do_pop) begin
            rdata_q <= mem_q[rptr_q[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign full_o   = full_q;
   assign empty_o  = empty_q;

endmodule

// File: rtl/rle_encode_fifo.sv
// Run-length encoder: closes runs of equal bytes into (char, count) pairs and
// buffers them in a pair FIFO. Optional RLE_STATS_EN adds byte/pair counters.
module rle_encode_fifo
   import rle_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_din,
   input  logic              flush,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              ready,
   output logic              full,
   output logic              empty
`ifdef RLE_STATS_EN
   ,
   output logic [15:0]       byte_cnt,
   output logic [15:0]       pair_cnt
`endif
);

   rle_state_t        state_q, state_d;
   logic [DATA_W-1:0] chr_q, chr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept_c;
   logic              push_c;
   rle_pair_t         pair_c;
   rle_pair_t         rdata;

   assign accept_c = wr_en && !full;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         chr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         chr_q   <= chr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Run FSM: a full run or a symbol change closes the open run; runs split at RMAX.
   always_comb begin
      state_d = state_q;
      chr_d   = chr_q;
      cnt_d   = cnt_q;
      push_c  = 1'b0;
      pair_c  = '{chr: chr_q, cnt: cnt_q};
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = RUN;
               chr_d   = data_din;
               cnt_d   = CNT_W'(1);
            end
         end
         RUN: begin
            if (accept_c) begin
               if ((data_din != chr_q) || (cnt_q == RMAX)) begin
                  push_c = 1'b1;
                  chr_d  = data_din;
                  cnt_d  = CNT_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (flush && !wr_en && !full) begin
               push_c  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   rle_pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RST),
      .push_i   (push_c),
      .wdata_i  (pair_c),
      .pop_i    (rd_en),
      .rdata_o  (rdata),
      .rvalid_o (ready),
      .full_o   (full),
      .empty_o  (empty)
   );

   assign data_o = rdata.chr;
   assign cnt_o  = rdata.cnt;

`ifdef RLE_STATS_EN
   logic [15:0] byte_cnt_q;
   logic [15:0] pair_cnt_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         byte_cnt_q <= '0;
         pair_cnt_q <= '0;
      end else begin
         byte_cnt_q <= byte_cnt_q + 16'(accept_c);
         pair_cnt_q <= pair_cnt_q + 16'(push_c);
      end
   end

   assign byte_cnt = byte_cnt_q;
   assign pair_cnt = pair_cnt_q;
`endif

endmodule

// File: tb/tb_rle_encode_fifo.sv
// Directed bench for rle_encode_fifo: a reference run model fills a pair
// scoreboard as stimulus is driven; pops are compared against it.
module tb_rle_encode_fifo;
   import rle_pkg::*;

   localparam int DEPTH = 8;

   logic              CLK = 1'b0;
   logic              RST;
   logic              wr_en;
   logic [DATA_W-1:0] data_din;
   logic              flush;
   logic              rd_en;
   logic [DATA_W-1:0] data_o;
   logic [CNT_W-1:0]  cnt_o;
   logic              ready;
   logic              full;
   logic              empty;
`ifdef RLE_STATS_EN
   logic [15:0]       byte_cnt;
   logic [15:0]       pair_cnt;
`endif

   rle_encode_fifo #(.DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .wr_en    (wr_en),
      .data_din (data_din),
      .flush    (flush),
      .rd_en    (rd_en),
      .data_o   (data_o),
      .cnt_o    (cnt_o),
      .ready    (ready),
      .full     (full),
      .empty    (empty)
`ifdef RLE_STATS_EN
      ,
      .byte_cnt (byte_cnt),
      .pair_cnt (pair_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int        n_pass  = 0;
   int        n_total = 0;

   rle_pair_t sb_q [$];
   bit        m_run;
   int        m_chr, m_cnt, m_occ;
   int        m_bytes, m_pairs;
   logic [7:0] exp_data;
   logic [3:0] exp_cnt;
   logic       exp_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push_pair();
      rle_pair_t p;
      p.chr = 8'(m_chr);
      p.cnt = 4'(m_cnt);
      sb_q.push_back(p);
      m_pairs++;
   endtask

   // One clock: drive inputs, advance the model, check outputs on the falling edge.
   task automatic cyc(input logic rst, input logic wr, input logic [7:0] din,
                      input logic fl, input logic rd);
      rle_pair_t p;
      bit pop, acc, push;
      RST = rst; wr_en = wr; data_din = din; flush = fl; rd_en = rd;
      if (!rst) begin
         sb_q.delete();
         m_run = 0; m_chr = 0; m_cnt = 0; m_occ = 0;
         m_bytes = 0; m_pairs = 0;
         exp_data = '0; exp_cnt = '0; exp_ready = 1'b0;
      end else begin
         pop  = rd && (m_occ > 0);
         acc  = wr && (m_occ < DEPTH);
         push = 0;
         exp_ready = 1'b0;
         if (pop) begin
            p = sb_q.pop_front();
            exp_data  = p.chr;
            exp_cnt   = p.cnt;
            exp_ready = 1'b1;
         end
         if (acc) begin
            m_bytes++;
            if (!m_run) begin
               m_run = 1; m_chr = int'(din); m_cnt = 1;
            end else if (int'(din) != m_chr || m_cnt == 15) begin
               push_pair(); push = 1;
               m_chr = int'(din); m_cnt = 1;
            end else begin
               m_cnt++;
            end
         end else if (!wr && fl && m_occ < DEPTH && m_run) begin
            push_pair(); push = 1;
            m_run = 0;
         end
         m_occ = m_occ + int'(push) - int'(pop);
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("data_o", 32'(data_o), 32'(exp_data));
      chk("cnt_o", 32'(cnt_o), 32'(exp_cnt));
      chk("full", 32'(full), 32'(m_occ == DEPTH));
      chk("empty", 32'(empty), 32'(m_occ == 0));
      if (ready === 1'b1) chk("cnt_nonzero", 32'(cnt_o != 0), 32'd1);
`ifdef RLE_STATS_EN
      chk("byte_cnt", 32'(byte_cnt), 32'(16'(m_bytes)));
      chk("pair_cnt", 32'(pair_cnt), 32'(16'(m_pairs)));
`endif
   endtask

   task automatic wr_b(input logic [7:0] b);
      cyc(1'b1, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic do_flush();
      cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   initial begin
      RST = 1'b0; wr_en = 1'b0; data_din = '0; flush = 1'b0; rd_en = 1'b0;

      // reset for two cycles
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

      // basic runs: (97,3) (98,2), then pop on empty gives no pulse
      wr_b(8'd97); wr_b(8'd97); wr_b(8'd97); wr_b(8'd98); wr_b(8'd98);
      do_flush();
      pop_n(3);

      // flush while idle does nothing
      do_flush();
      pop_n(1);

      // 17 x 99 splits into (99,15) and (99,2)
      for (int i = 0; i < 17; i++) wr_b(8'd99);
      do_flush();
      pop_n(3);

      // fill the FIFO with distinct bytes, drop a write while full
      for (int i = 100; i <= 108; i++) wr_b(8'(i));
      wr_b(8'd109);
      do_flush();
      pop_n(1);
      wr_b(8'd110);
      pop_n(8);
      do_flush();
      pop_n(2);

      // concurrent push and pop keeps occupancy constant
      wr_b(8'd1); wr_b(8'd2);
      for (int i = 3; i < 10; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'd0, 1'b1, 1'b1);
      pop_n(2);

      // reset mid-run with three stored pairs
      wr_b(8'd10); wr_b(8'd11); wr_b(8'd12); wr_b(8'd13); wr_b(8'd13);
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      pop_n(1);
      wr_b(8'd20); wr_b(8'd20); wr_b(8'd21);
      do_flush();
      pop_n(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
